// File: rtl/sig_meter.sv
`default_nettype none
// ============================================================================
// Module   : sig_meter
// Brief    : Threshold/hysteresis slicer with period, high-time and optional
//            min/max measurement of an 8-bit sample stream; sticky loss-of-
//            signal flag. Optional min/max tracking: define SIG_METER_MINMAX_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sig_meter #(
    parameter int CNT_W       = 32,
    parameter int HYST        = 8,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [7:0]       threshold,
    input  logic [7:0]       sample_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic [7:0]       min_out,
    output logic [7:0]       max_out,
    output logic             result_valid,
    output logic             no_signal
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    localparam logic [8:0]       c_hyst    = 9'(HYST);
    localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

    // Levels are formed in 9 bits so the saturation test sees the carry/borrow.
    function automatic logic [7:0] f_thr_hi(input logic [7:0] thr);
        logic [8:0] s;
        s = {1'b0, thr} + c_hyst;
        return (s > 9'd255) ? 8'hFF : s[7:0];
    endfunction

    function automatic logic [7:0] f_thr_lo(input logic [7:0] thr);
        logic [8:0] d;
        d = {1'b0, thr} - c_hyst;
        return ({1'b0, thr} < c_hyst) ? 8'h00 : d[7:0];
    endfunction

    state_t           state_q, state_d;
    logic [7:0]       thr_q, thr_d;
    logic             lvl_q, lvl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] period_out_q, period_out_d;
    logic [CNT_W-1:0] high_out_q, high_out_d;
    logic             valid_q, valid_d;
    logic             nosig_q, nosig_d;

    logic [7:0]       w_thr_hi;
    logic [7:0]       w_thr_lo;
    logic             w_lvl_next;
    logic             w_rise;

    assign w_thr_hi   = f_thr_hi(thr_q);
    assign w_thr_lo   = f_thr_lo(thr_q);
    assign w_lvl_next = lvl_q ? (sample_in > w_thr_lo) : (sample_in >= w_thr_hi);
    assign w_rise     = ~lvl_q & w_lvl_next;

`ifdef SIG_METER_MINMAX_EN
    logic [7:0] min_q, min_d;
    logic [7:0] max_q, max_d;
    logic [7:0] min_out_q, min_out_d;
    logic [7:0] max_out_q, max_out_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            thr_q        <= 8'h00;
            lvl_q        <= 1'b0;
            cnt_q        <= '0;
            high_q       <= '0;
            period_out_q <= '0;
            high_out_q   <= '0;
            valid_q      <= 1'b0;
            nosig_q      <= 1'b0;
`ifdef SIG_METER_MINMAX_EN
            min_q        <= 8'h00;
            max_q        <= 8'h00;
            min_out_q    <= 8'h00;
            max_out_q    <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            thr_q        <= thr_d;
            lvl_q        <= lvl_d;
            cnt_q        <= cnt_d;
            high_q       <= high_d;
            period_out_q <= period_out_d;
            high_out_q   <= high_out_d;
            valid_q      <= valid_d;
            nosig_q      <= nosig_d;
`ifdef SIG_METER_MINMAX_EN
            min_q        <= min_d;
            max_q        <= max_d;
            min_out_q    <= min_out_d;
            max_out_q    <= max_out_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        thr_d        = thr_q;
        lvl_d        = lvl_q;
        cnt_d        = cnt_q;
        high_d       = high_q;
        period_out_d = period_out_q;
        high_out_d   = high_out_q;
        valid_d      = 1'b0;
        nosig_d      = nosig_q;
`ifdef SIG_METER_MINMAX_EN
        min_d        = min_q;
        max_d        = max_q;
        min_out_d    = min_out_q;
        max_out_d    = max_out_q;
`endif
        if (!en) begin
            state_d = ST_IDLE;
            lvl_d   = 1'b0;
            cnt_d   = '0;
            high_d  = '0;
            nosig_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Arming seeds the slicer from the new threshold so a
                    // signal already high does not count as a crossing.
                    state_d = ST_SYNC;
                    thr_d   = threshold;
                    lvl_d   = (sample_in >= f_thr_hi(threshold));
                    cnt_d   = '0;
                    high_d  = '0;
                end
                ST_SYNC: begin
                    lvl_d = w_lvl_next;
                    if (w_rise) begin
                        state_d = ST_MEASURE;
                        cnt_d   = c_one;
                        high_d  = c_one;
`ifdef SIG_METER_MINMAX_EN
                        min_d   = sample_in;
                        max_d   = sample_in;
`endif
                    end else if (cnt_q == c_timeout) begin
                        nosig_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + c_one;
                    end
                end
                ST_MEASURE: begin
                    lvl_d = w_lvl_next;
                    if (w_rise) begin
                        period_out_d = cnt_q;
                        high_out_d   = high_q;
                        valid_d      = 1'b1;
                        nosig_d      = 1'b0;
                        cnt_d        = c_one;
                        high_d       = c_one;
`ifdef SIG_METER_MINMAX_EN
                        min_out_d    = min_q;
                        max_out_d    = max_q;
                        min_d        = sample_in;
                        max_d        = sample_in;
`endif
                    end else if (cnt_q == c_timeout) begin
                        nosig_d = 1'b1;
                        state_d = ST_SYNC;
                        cnt_d   = '0;
                        high_d  = '0;
                    end else begin
                        cnt_d  = cnt_q + c_one;
                        high_d = high_q + CNT_W'(w_lvl_next);
`ifdef SIG_METER_MINMAX_EN
                        if (sample_in < min_q) min_d = sample_in;
                        if (sample_in > max_q) max_d = sample_in;
`endif
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign period_out   = period_out_q;
    assign high_out     = high_out_q;
    assign result_valid = valid_q;
    assign no_signal    = nosig_q;

`ifdef SIG_METER_MINMAX_EN
    assign min_out = min_out_q;
    assign max_out = max_out_q;
`else
    assign min_out = 8'h00;
    assign max_out = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sig_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sig_meter
// Brief    : Directed self-checking bench for sig_meter (short timeout).
//            Min/max expectations follow SIG_METER_MINMAX_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sig_meter;

    localparam int CNT_W       = 16;
    localparam int TIMEOUT_CYC = 40;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [7:0]       threshold;
    logic [7:0]       sample_in;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic [7:0]       min_out;
    logic [7:0]       max_out;
    logic             result_valid;
    logic             no_signal;

    int tests   = 0;
    int fails   = 0;
    int strobes = 0;
    int ph      = 0;

    sig_meter #(
        .CNT_W       (CNT_W),
        .HYST        (8),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .threshold    (threshold),
        .sample_in    (sample_in),
        .period_out   (period_out),
        .high_out     (high_out),
        .min_out      (min_out),
        .max_out      (max_out),
        .result_valid (result_valid),
        .no_signal    (no_signal)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mm(input logic [7:0] v);
`ifdef SIG_METER_MINMAX_EN
        return v;
`else
        return 8'h00;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic [7:0] s);
        sample_in = s;
        @(posedge clk);
        #1;
        if (result_valid) strobes++;
    endtask

    task automatic run_sq(input int n);
        for (int i = 0; i < n; i++) begin
            tick(((ph / 4) % 2) != 0 ? 8'd255 : 8'd0);
            ph++;
        end
    endtask

    task automatic run_pwm(input int n);
        for (int i = 0; i < n; i++) begin
            tick((ph % 8) < 3 ? 8'd255 : 8'd128);
            ph++;
        end
    endtask

    task automatic run_noise(input int n);
        for (int i = 0; i < n; i++) begin
            tick((ph % 2) == 0 ? 8'd130 : 8'd126);
            ph++;
        end
    endtask

    task automatic chk_result(input string tag, input int per, input int hi,
                              input logic [7:0] mn, input logic [7:0] mx);
        chk({tag, "_period"}, 32'(period_out), 32'(per));
        chk({tag, "_high"},   32'(high_out),   32'(hi));
        chk({tag, "_min"},    32'(min_out),    32'(mm(mn)));
        chk({tag, "_max"},    32'(max_out),    32'(mm(mx)));
    endtask

    initial begin
        // Reset with random inputs
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            en        = 1'($urandom);
            threshold = 8'($urandom);
            tick(8'($urandom));
        end
        chk("rst_valid", 32'(result_valid), 0);
        chk("rst_nosig", 32'(no_signal), 0);
        chk_result("rst", 0, 0, 8'd0, 8'd0);
        rst = 1'b0;
        en  = 1'b0;
        strobes = 0;
        for (int i = 0; i < 10; i++) tick(8'($urandom));
        chk("idle_strobes", 32'(strobes), 0);

        // Square wave 0x4 / 255x4, threshold 128
        threshold = 8'd128;
        en = 1'b1;
        ph = 0;
        strobes = 0;
        run_sq(12);
        chk("sq_no_early_strobe", 32'(strobes), 0);
        run_sq(1);
        chk("sq_first_valid", 32'(result_valid), 1);
        chk_result("sq1", 8, 4, 8'd0, 8'd255);
        strobes = 0;
        run_sq(7);
        chk("sq_gap_strobes", 32'(strobes), 0);
        run_sq(1);
        chk("sq_second_valid", 32'(result_valid), 1);
        chk_result("sq2", 8, 4, 8'd0, 8'd255);
        chk("sq_nosig", 32'(no_signal), 0);

        // PWM at threshold 128: slicer never falls, timeout without strobe
        en = 1'b0;
        tick(8'd0);
        threshold = 8'd128;
        en = 1'b1;
        ph = 0;
        strobes = 0;
        run_pwm(25);
        chk("pwm128_nosig_early", 32'(no_signal), 0);
        run_pwm(35);
        chk("pwm128_nosig_late", 32'(no_signal), 1);
        chk("pwm128_strobes", 32'(strobes), 0);
        chk_result("pwm128_hold", 8, 4, 8'd0, 8'd255);

        // Re-arm at threshold 192
        en = 1'b0;
        tick(8'd0);
        chk("disable_clears_nosig", 32'(no_signal), 0);
        threshold = 8'd192;
        en = 1'b1;
        ph = 0;
        strobes = 0;
        run_pwm(16);
        chk("pwm192_no_early_strobe", 32'(strobes), 0);
        run_pwm(1);
        chk("pwm192_valid", 32'(result_valid), 1);
        chk_result("pwm192", 8, 3, 8'd128, 8'd255);

        // Mid-measure disable: 5 cycles after first crossing
        en = 1'b0;
        tick(8'd0);
        threshold = 8'd128;
        en = 1'b1;
        ph = 0;
        strobes = 0;
        run_sq(10);
        en = 1'b0;
        tick(8'd255);
        tick(8'd255);
        chk("midmeas_strobes", 32'(strobes), 0);
        chk_result("midmeas_hold", 8, 3, 8'd128, 8'd255);
        en = 1'b1;
        ph = 0;
        run_sq(12);
        chk("rearm_no_early_strobe", 32'(strobes), 0);
        run_sq(1);
        chk("rearm_valid", 32'(result_valid), 1);
        chk_result("rearm", 8, 4, 8'd0, 8'd255);

        // Noise 130/126 around 128: no crossing, timeout; clean square clears
        en = 1'b0;
        tick(8'd0);
        threshold = 8'd128;
        en = 1'b1;
        ph = 0;
        strobes = 0;
        run_noise(60);
        chk("noise_nosig", 32'(no_signal), 1);
        chk("noise_strobes", 32'(strobes), 0);
        threshold = 8'd0;  // ignored while enabled
        ph = 0;
        run_sq(12);
        chk("noise_nosig_sticky", 32'(no_signal), 1);
        run_sq(1);
        chk("recover_valid", 32'(result_valid), 1);
        chk("recover_nosig", 32'(no_signal), 0);
        chk_result("recover", 8, 4, 8'd0, 8'd255);

        // Reset in the middle of a measurement
        run_sq(5);
        rst = 1'b1;
        tick(8'd255);
        rst = 1'b0;
        en  = 1'b0;
        chk("midrst_valid", 32'(result_valid), 0);
        chk("midrst_nosig", 32'(no_signal), 0);
        chk_result("midrst", 0, 0, 8'd0, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sig_meter.md
# sig_meter

Waveform measurement receiver for the function generator's 8-bit sample stream. It slices each incoming sample against a programmable threshold with hysteresis, then measures each full period between rising crossings: period length in clocks, high time in clocks, and optionally the minimum and maximum sample value. Results are published with a one-cycle valid strobe. The block sits on the generator output for self-check and readback, and a loss of signal is reported as a sticky flag.

## Interface
- `CNT_W`, default 32: width of the period and high-time counters and their outputs.
- `HYST`, default 8: hysteresis half-width in LSBs.
- `TIMEOUT_CYC`, default 1_000_000: cycles without a rising crossing before loss of signal. Must be less than 2^CNT_W.
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous reset, active-high.
- `en`, in, 1: measurement enable.
- `threshold`, in, 8: slicing level, latched on entry to SYNC.
- `sample_in`, in, 8: waveform sample, consumed every clock.
- `period_out`, out, CNT_W: last measured period in clocks.
- `high_out`, out, CNT_W: last measured high time in clocks.
- `min_out`, out, 8: minimum sample seen in the last period.
- `max_out`, out, 8: maximum sample seen in the last period.
- `result_valid`, out, 1: one-cycle strobe when the outputs above update.
- `no_signal`, out, 1: sticky timeout flag. Cleared by the next result, by `en`=0, or by `rst`.

## Operation
- Threshold levels are computed in 9 bits and then saturated:
  - thr_hi = min(thr_l + HYST, 255)
  - thr_lo = max(thr_l − HYST, 0)
- Slicer `lvl` (registered):
  - 0→1 when `lvl`=0 and `sample_in` ≥ thr_hi.
  - 1→0 when `lvl`=1 and `sample_in` ≤ thr_lo.
  - Otherwise it holds.
- A rising crossing is the clock edge at which `lvl` goes 0→1.
- FSM states: IDLE, SYNC, MEASURE. `en`=0 forces IDLE from any state, and this has priority over every other transition.
- IDLE:
  - Counters are 0 and `lvl`=0.
  - Result outputs hold their last values.
  - When `en`=1, go to SYNC. On that edge: thr_l ← `threshold`, `lvl` ← (`sample_in` ≥ thr_hi), `cnt` ← 0. Entering SYNC is never a crossing.
- SYNC:
  - `cnt` increments each clock.
  - On a rising crossing: period_cnt ← 1, high_cnt ← 1, min/max ← `sample_in`, go to MEASURE.
  - If `cnt` reaches TIMEOUT_CYC first: `no_signal` ← 1, `cnt` ← 0, stay in SYNC.
- MEASURE, edges without a crossing:
  - period_cnt += 1.
  - high_cnt += next `lvl`.
  - min/max update with `sample_in`.
- MEASURE, on a rising crossing:
  - `period_out` ← period_cnt, `high_out` ← high_cnt, `min_out`/`max_out` ← tracked values.
  - `result_valid` ← 1 and `no_signal` ← 0.
  - Counters restart at 1, and min/max restart at `sample_in`.
- MEASURE timeout: if period_cnt = TIMEOUT_CYC and this edge is not a crossing, set `no_signal` ← 1, go to SYNC, `cnt` ← 0. No strobe is issued.
- Resulting semantics: N high samples followed by M low samples give `period_out` = N+M and `high_out` = N.
- Counters never wrap, because the timeout fires first.

## Timing
- Reset: all outputs are 0, state is IDLE, `lvl`=0, thr_l=0.
- `result_valid` and the result outputs update on the same edge as the terminating crossing. That edge is one clock after the `sample_in` that satisfies thr_hi.
- The first result arrives at the second rising crossing after `en` goes high. A partial first period is never reported.
- `result_valid` is high for exactly one cycle and never on consecutive cycles, since the minimum period is 2.
- Deasserting `en` in MEASURE discards the measurement in progress. No strobe is issued, and `no_signal` clears on the next edge.
- `threshold` changes while `en`=1 are ignored until the next pass through IDLE.
- `rst` mid-measurement behaves exactly like power-on reset.

## Configuration
- `SIG_METER_MINMAX_EN`:
  - Defined: min/max tracking logic is present and `min_out`/`max_out` behave as above.
  - Undefined: the tracking registers are removed and `min_out`/`max_out` are tied to 8'h00.
- Ports are identical in both builds. Period, high time, strobe and timeout behaviour is unchanged.

## Test plan
- Reset: assert `rst` for 3 cycles with random inputs → every output is 0; with `en`=0, `result_valid` never fires.
- Square wave: stream of 255×4, 0×4 repeating, `threshold`=128 → first strobe at the second crossing; `period_out`=8, `high_out`=4, `min_out`=0, `max_out`=255; strobes thereafter every 8 cycles.
- PWM-style stream, 255×3 then 128×5, sliced two ways:
  - With `threshold`=128, thr_lo=120, so the slicer never falls → no strobe; `no_signal`=1 after TIMEOUT_CYC cycles.
  - Re-arm with `threshold`=192 → `period_out`=8, `high_out`=3, `min_out`=128, `max_out`=255.
- Noise rejection: samples alternating 130/126 with `threshold`=128 → no crossings, `no_signal` set at timeout. A subsequent clean square wave clears it on the first result.
- Mid-measure disable: drop `en` 5 cycles after the first crossing → no strobe; outputs hold their prior values. Re-enable → first result appears only after two new crossings.
- Macro undefined, square-wave stimulus as above → `period_out`/`high_out` identical to the macro-defined run; `min_out`=`max_out`=0.
